// File: rtl/mem_port_arbiter.sv
// Arbitrates the main-memory port between 8-word line fills and buffered write-through stores.
// Fills win over stores unless a buffered store targets the line being filled.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32,
  parameter int WBUF_DEPTH = 4,
  parameter int LINE_WORDS = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fill_req,
  input  logic [ADDR_WIDTH-1:0]         fill_line_addr,
  output logic [WORD_WIDTH-1:0]         fill_data,
  output logic                          fill_data_valid,
  output logic [$clog2(LINE_WORDS)-1:0] fill_word_idx,
  output logic                          fill_done,
  input  logic                          wr_req,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [WORD_WIDTH-1:0]         wr_data,
  output logic                          wr_ready,
  output logic [ADDR_WIDTH-1:0]         memory_addr,
  output logic                          memory_write_en,
  output logic [WORD_WIDTH-1:0]         memory_write_data,
  output logic                          memory_read_addr_valid,
  input  logic [WORD_WIDTH-1:0]         memory_read_data,
  input  logic                          memory_read_ready,
  input  logic                          memory_read_valid
);

  localparam int LB = $clog2(LINE_WORDS);
  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [LB:0]   LINE_CNT = (LB+1)'(LINE_WORDS);
  localparam logic [LB-1:0] LAST_IDX = LB'(LINE_WORDS - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(WBUF_DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] buf_addr [WBUF_DEPTH];
  logic [WORD_WIDTH-1:0] buf_data [WBUF_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  push, pop, hazard;

  logic [LB:0]           issue_cnt_q, issue_cnt_d;
  logic [LB-1:0]         ret_cnt_q, ret_cnt_d;
  logic                  hold_q, hold_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wen_q, wen_d;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rav_q, rav_d;
  logic [WORD_WIDTH-1:0] fdata_q, fdata_d;
  logic                  fvalid_q, fvalid_d;
  logic [LB-1:0]         fidx_q, fidx_d;
  logic                  fdone_q, fdone_d;

  assign wr_ready = (count_q != FULL_CNT);
  assign push     = wr_req && wr_ready;

  assign memory_addr            = addr_q;
  assign memory_write_en        = wen_q;
  assign memory_write_data      = wdata_q;
  assign memory_read_addr_valid = rav_q;
  assign fill_data              = fdata_q;
  assign fill_data_valid        = fvalid_q;
  assign fill_word_idx          = fidx_q;
  assign fill_done              = fdone_q;

  // Only entries between rd_ptr and rd_ptr+count are live; stale slots must not raise a hazard.
  always_comb begin
    logic [PW-1:0] idx;
    hazard = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) &&
          (buf_addr[idx][ADDR_WIDTH-1:LB] == fill_line_addr[ADDR_WIDTH-1:LB]))
        hazard = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr[wr_ptr_q] <= wr_addr;
      buf_data[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      hold_q      <= 1'b0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      rav_q       <= 1'b0;
      fdata_q     <= '0;
      fvalid_q    <= 1'b0;
      fidx_q      <= '0;
      fdone_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      hold_q      <= hold_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      rav_q       <= rav_d;
      fdata_q     <= fdata_d;
      fvalid_q    <= fvalid_d;
      fidx_q      <= fidx_d;
      fdone_q     <= fdone_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    hold_d      = 1'b0;
    addr_d      = addr_q;
    wen_d       = 1'b0;
    wdata_d     = wdata_q;
    rav_d       = 1'b0;
    fdata_d     = fdata_q;
    fvalid_d    = 1'b0;
    fidx_d      = fidx_q;
    fdone_d     = 1'b0;
    pop         = 1'b0;

    unique case (state_q)
      IDLE: begin
        // hold_q blocks a new fill for one cycle after fill_done so the requester can drop fill_req.
        if (fill_req && !hazard && !hold_q && memory_read_ready) begin
          addr_d      = fill_line_addr;
          rav_d       = 1'b1;
          issue_cnt_d = (LB+1)'(1);
          ret_cnt_d   = '0;
          state_d     = FILL;
        end else if ((count_q != '0) && memory_read_ready) begin
          addr_d  = buf_addr[rd_ptr_q];
          wdata_d = buf_data[rd_ptr_q];
          wen_d   = 1'b1;
          pop     = 1'b1;
        end
      end

      FILL: begin
        if ((issue_cnt_q < LINE_CNT) && memory_read_ready) begin
          addr_d      = fill_line_addr + ADDR_WIDTH'(issue_cnt_q);
          rav_d       = 1'b1;
          issue_cnt_d = issue_cnt_q + (LB+1)'(1);
        end
        if (memory_read_valid) begin
          fdata_d   = memory_read_data;
          fvalid_d  = 1'b1;
          fidx_d    = ret_cnt_q;
          ret_cnt_d = ret_cnt_q + LB'(1);
          if (ret_cnt_q == LAST_IDX) begin
            fdone_d     = 1'b1;
            issue_cnt_d = '0;
            ret_cnt_d   = '0;
            hold_d      = 1'b1;
            state_d     = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
